// File: rtl/div_ctrl_if.sv
// Issue/result bundle between the execute stage and the RV32M divide sequencer.
// The slave modport is the divider side; the master modport is the issuing side.
interface div_ctrl_if #(parameter int XLEN = 32);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic [4:0]      rd_addr_i;
  logic            flush_i;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_addr_o;
  logic            ready_o;
  logic            busy_o;
  logic            hold_flag_o;

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
    output result_o, rd_addr_o, ready_o, busy_o, hold_flag_o
  );
  modport master (
    output start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
    input  result_o, rd_addr_o, ready_o, busy_o, hold_flag_o
  );
endinterface

// File: rtl/div_ctrl.sv
// RV32M DIV/DIVU/REM/REMU sequencer: restoring shift-subtract, one quotient bit
// per cycle, with stall request to ctrl and flush abort.
module div_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  div_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic       sel_rem;
    logic       neg_q;
    logic       neg_r;
    logic [4:0] rd_addr;
  } req_t;

  state_t          state;
  req_t            req;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] dvd, dsr, rem;

  logic            accept;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN:0]   rem_sh, diff;
  logic            q_bit;
  logic [XLEN-1:0] dvd_nxt, rem_nxt, q_fix, r_fix;

  assign accept = (state == IDLE) & bus.start_i & bus.op_i[2] & ~bus.flush_i;

  // op_i[0]=0 selects the signed variants (DIV, REM)
  assign a_neg = ~bus.op_i[0] & bus.dividend_i[XLEN-1];
  assign b_neg = ~bus.op_i[0] & bus.divisor_i[XLEN-1];
  assign a_abs = a_neg ? -bus.dividend_i : bus.dividend_i;
  assign b_abs = b_neg ? -bus.divisor_i  : bus.divisor_i;

  // dvd shifts out dividend bits at the top and collects quotient bits at the bottom
  assign rem_sh  = {rem, dvd[XLEN-1]};
  assign diff    = rem_sh - {1'b0, dsr};
  assign q_bit   = ~diff[XLEN];
  assign rem_nxt = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign dvd_nxt = {dvd[XLEN-2:0], q_bit};
  assign q_fix   = req.neg_q ? -dvd_nxt : dvd_nxt;
  assign r_fix   = req.neg_r ? -rem_nxt : rem_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      req           <= '0;
      cnt           <= '0;
      dvd           <= '0;
      dsr           <= '0;
      rem           <= '0;
      bus.result_o  <= '0;
      bus.rd_addr_o <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          req <= '{sel_rem: bus.op_i[1], neg_q: a_neg ^ b_neg, neg_r: a_neg,
                   rd_addr: bus.rd_addr_i};
          dvd <= a_abs;
          dsr <= b_abs;
          rem <= '0;
          cnt <= '0;
          if (bus.divisor_i == '0) begin
            state         <= DONE;
            bus.result_o  <= bus.op_i[1] ? bus.dividend_i : '1;
            bus.rd_addr_o <= bus.rd_addr_i;
          end else begin
            state <= CALC;
          end
        end
        CALC: if (bus.flush_i) begin
          state <= IDLE;
        end else begin
          dvd <= dvd_nxt;
          rem <= rem_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN-1)) begin
            state         <= DONE;
            bus.result_o  <= req.sel_rem ? r_fix : q_fix;
            bus.rd_addr_o <= req.rd_addr;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready_o     = (state == DONE) & ~bus.flush_i;
  assign bus.busy_o      = (state == CALC);
  assign bus.hold_flag_o = accept | (state == CALC);

endmodule
